// File: rtl/rd53_por_pkg.sv
// Shared types, defaults and width helper for the RD53 power-on reset sequencer.
// Optional build macro used by the sequencer: RD53_POR_OVERRIDE_EN.
package rd53_por_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } por_state_t;

    localparam int unsigned POR_N_CH_DEF        = 4;
    localparam int unsigned POR_STARTUP_CYC_DEF = 64;
    localparam int unsigned POR_STAGGER_CYC_DEF = 8;
    localparam int unsigned POR_FILT_LEN_DEF    = 4;

    // Cycle counter must hold the larger of the two terminal counts.
    function automatic int unsigned por_cnt_w(input int unsigned startup,
                                              input int unsigned stagger);
        return $clog2(((startup > stagger) ? startup : stagger) + 1);
    endfunction

endpackage

// File: rtl/rd53_por_trig_filter.sv
// Synchronises POR_EXT_CAP and emits a single TRIG pulse per qualified low run.
module rd53_por_trig_filter
    import rd53_por_pkg::*;
#(
    parameter int unsigned FILT_LEN = POR_FILT_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic POR_EXT_CAP,
    output logic TRIG
);

    localparam int unsigned     RUN_W   = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

    logic             sync1_q;
    logic             sync2_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             armed_q;
    logic             armed_d;
    logic             trig_q;
    logic             trig_d;
    logic             fire;

    // A high sample re-arms and clears the run; firing disarms until then.
    always_comb begin
        fire    = armed_q && (run_q == RUN_MAX);
        trig_d  = fire;
        run_d   = run_q;
        armed_d = armed_q;
        if (sync2_q) begin
            run_d   = '0;
            armed_d = 1'b1;
        end else begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            if (fire) begin
                armed_d = 1'b0;
            end
        end
    end

    // Synchroniser resets to the idle (high) level so reset cannot look like a trigger.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            run_q   <= '0;
            armed_q <= 1'b1;
            trig_q  <= 1'b0;
        end else begin
            sync1_q <= POR_EXT_CAP;
            sync2_q <= sync1_q;
            run_q   <= run_d;
            armed_q <= armed_d;
            trig_q  <= trig_d;
        end
    end

    assign TRIG = trig_q;

endmodule

// File: rtl/rd53_por_reset_sequencer.sv
// Staggered power-on reset release for N_CH core domains, re-armed by POR_EXT_CAP.
// Build macro RD53_POR_OVERRIDE_EN adds a direct override of POR_OUT_B.
module rd53_por_reset_sequencer
    import rd53_por_pkg::*;
#(
    parameter int unsigned N_CH        = POR_N_CH_DEF,
    parameter int unsigned STARTUP_CYC = POR_STARTUP_CYC_DEF,
    parameter int unsigned STAGGER_CYC = POR_STAGGER_CYC_DEF,
    parameter int unsigned FILT_LEN    = POR_FILT_LEN_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            POR_EXT_CAP,
`ifdef RD53_POR_OVERRIDE_EN
    input  logic            POR_OVR_EN,
    input  logic [N_CH-1:0] POR_OVR_VAL,
`endif
    output logic [N_CH-1:0] POR_OUT_B,
    output logic            POR_DONE,
    output logic            POR_BUSY
);

    localparam int unsigned      CNT_W   = por_cnt_w(STARTUP_CYC, STAGGER_CYC);
    localparam int unsigned      IDX_W   = $clog2(N_CH + 1);
    localparam logic [CNT_W-1:0] CNT_SU  = CNT_W'(STARTUP_CYC);
    localparam logic [CNT_W-1:0] CNT_ST  = CNT_W'(STAGGER_CYC);
    localparam logic [IDX_W-1:0] IDX_LST = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  CH0     = N_CH'(1);

    por_state_t       state_q;
    por_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [N_CH-1:0]  rel_q;
    logic [N_CH-1:0]  rel_d;
    logic             done_q;
    logic             done_d;
    logic             busy_q;
    logic             busy_d;
    logic             trig;

    rd53_por_trig_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_trig_filter (
        .CLK         (CLK),
        .RST         (RST),
        .POR_EXT_CAP (POR_EXT_CAP),
        .TRIG        (trig)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        done_d  = done_q;
        busy_d  = busy_q;
        if (trig) begin
            // The response edge itself is cycle 0 of the restarted sequence.
            state_d = ASSERT;
            cnt_d   = CNT_W'(1);
            idx_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == CNT_SU) begin
                        rel_d = rel_q | CH0;
                        idx_d = IDX_W'(1);
                        cnt_d = CNT_W'(1);
                        if (N_CH == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_ST) begin
                        rel_d = rel_q | (CH0 << idx_q);
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = CNT_W'(1);
                        if (idx_q == IDX_LST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

`ifdef RD53_POR_OVERRIDE_EN
    logic [N_CH-1:0] out_q;

    // Override only steers the pin register; the sequence keeps running underneath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q <= '0;
        end else if (POR_OVR_EN) begin
            out_q <= POR_OVR_VAL;
        end else begin
            out_q <= rel_d;
        end
    end

    assign POR_OUT_B = out_q;
`else
    assign POR_OUT_B = rel_q;
`endif

    assign POR_DONE = done_q;
    assign POR_BUSY = busy_q;

endmodule

// File: tb/tb_rd53_por_reset_sequencer.sv
// Self-checking bench for rd53_por_reset_sequencer against a cycle-index reference model.
module tb_rd53_por_reset_sequencer;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned STARTUP_CYC = 64;
    localparam int unsigned STAGGER_CYC = 8;
    localparam int unsigned FILT_LEN    = 4;

    logic            CLK;
    logic            RST;
    logic            POR_EXT_CAP;
    logic [N_CH-1:0] POR_OUT_B;
    logic            POR_DONE;
    logic            POR_BUSY;
`ifdef RD53_POR_OVERRIDE_EN
    logic            POR_OVR_EN;
    logic [N_CH-1:0] POR_OVR_VAL;
`endif

    rd53_por_reset_sequencer #(
        .N_CH        (N_CH),
        .STARTUP_CYC (STARTUP_CYC),
        .STAGGER_CYC (STAGGER_CYC),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .POR_EXT_CAP (POR_EXT_CAP),
`ifdef RD53_POR_OVERRIDE_EN
        .POR_OVR_EN  (POR_OVR_EN),
        .POR_OVR_VAL (POR_OVR_VAL),
`endif
        .POR_OUT_B   (POR_OUT_B),
        .POR_DONE    (POR_DONE),
        .POR_BUSY    (POR_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position inside the current sequence plus pin-level trigger rules.
    int              seq_t   = 0;
    int              lowrun  = 0;
    bit              armed   = 1'b1;
    int              edge_n  = 0;
    int              pend[$];
    logic [N_CH-1:0] exp_out = '0;
    bit              exp_done = 1'b0;
    bit              exp_busy = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, act, exp);
        end
    endtask

    task automatic step();
        bit trig_now;
        @(posedge CLK);
        edge_n++;
        trig_now = 1'b0;
        if (RST) begin
            pend.delete();
            lowrun = 0;
            armed  = 1'b1;
        end else begin
            if (pend.size() > 0 && pend[0] == edge_n) begin
                trig_now = 1'b1;
                void'(pend.pop_front());
            end
            if (!POR_EXT_CAP) begin
                if (lowrun < int'(FILT_LEN)) lowrun++;
                // FILT_LEN-th low sample qualifies; response lands 4 edges later.
                if (lowrun == int'(FILT_LEN) && armed) begin
                    pend.push_back(edge_n + 4);
                    armed = 1'b0;
                end
            end else begin
                lowrun = 0;
                armed  = 1'b1;
            end
        end
        if (RST || trig_now) begin
            exp_out  = '0;
            exp_done = 1'b0;
            exp_busy = 1'b1;
            seq_t    = RST ? 0 : 1;
        end else begin
            for (int k = 0; k < int'(N_CH); k++) begin
                exp_out[k] = (seq_t >= int'(STARTUP_CYC) + k * int'(STAGGER_CYC));
            end
            exp_done = (seq_t >= int'(STARTUP_CYC) + (int'(N_CH) - 1) * int'(STAGGER_CYC));
            exp_busy = !exp_done;
            if (seq_t < 1000000) seq_t++;
        end
`ifdef RD53_POR_OVERRIDE_EN
        if (!RST && POR_OVR_EN) exp_out = POR_OVR_VAL;
`endif
        #1;
        check("out_b", 32'(POR_OUT_B), 32'(exp_out));
        check("done", 32'(POR_DONE), 32'(exp_done));
        check("busy", 32'(POR_BUSY), 32'(exp_busy));
    endtask

    initial begin
        int burst;
        bit lvl;
        RST         = 1'b1;
        POR_EXT_CAP = 1'b1;
`ifdef RD53_POR_OVERRIDE_EN
        POR_OVR_EN  = 1'b0;
        POR_OVR_VAL = '0;
`endif
        repeat (5) step();
        RST = 1'b0;

        // Plain power-up release.
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 63) check("pu_63", 32'(POR_OUT_B), 32'h0);
            if (i == 64) check("pu_64", 32'(POR_OUT_B), 32'h1);
            if (i == 72) check("pu_72", 32'(POR_OUT_B), 32'h3);
            if (i == 80) check("pu_80", 32'(POR_OUT_B), 32'h7);
            if (i == 87) check("pu_87_done", 32'(POR_DONE), 32'h0);
            if (i == 88) begin
                check("pu_88", 32'(POR_OUT_B), 32'hf);
                check("pu_88_done", 32'(POR_DONE), 32'h1);
                check("pu_88_busy", 32'(POR_BUSY), 32'h0);
            end
        end

        // Short glitch is filtered out.
        POR_EXT_CAP = 1'b0;
        repeat (3) step();
        POR_EXT_CAP = 1'b1;
        repeat (20) step();
        check("glitch_out", 32'(POR_OUT_B), 32'hf);
        check("glitch_done", 32'(POR_DONE), 32'h1);

        // Stuck-low pin retriggers exactly once.
        POR_EXT_CAP = 1'b0;
        for (int j = 0; j < 120; j++) begin
            step();
            if (j == 6)  check("trig_pre", 32'(POR_OUT_B), 32'hf);
            if (j == 7)  check("trig_resp", 32'(POR_OUT_B), 32'h0);
            if (j == 70) check("trig_70", 32'(POR_OUT_B), 32'h0);
            if (j == 71) check("trig_71", 32'(POR_OUT_B), 32'h1);
            if (j == 95) check("trig_95_done", 32'(POR_DONE), 32'h1);
        end
        check("stuck_once", 32'(POR_OUT_B), 32'hf);
        POR_EXT_CAP = 1'b1;
        repeat (10) step();

        // Retrigger during RELEASE.
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 160; i++) begin
            POR_EXT_CAP = (i >= 68 && i < 73) ? 1'b0 : 1'b1;
            step();
            if (i == 74)  check("rel_trig_pre", 32'(POR_OUT_B), 32'h3);
            if (i == 75)  check("rel_trig_resp", 32'(POR_OUT_B), 32'h0);
            if (i == 138) check("rel_trig_138", 32'(POR_OUT_B), 32'h0);
            if (i == 139) check("rel_trig_139", 32'(POR_OUT_B), 32'h1);
        end

        // RST coincident with a qualified trigger.
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 70; i++) begin
            POR_EXT_CAP = (i >= 63) ? 1'b0 : 1'b1;
            step();
        end
        RST         = 1'b1;
        POR_EXT_CAP = 1'b1;
        step();
        check("rst_trig_out", 32'(POR_OUT_B), 32'h0);
        check("rst_trig_busy", 32'(POR_BUSY), 32'h1);
        RST = 1'b0;
        for (int j = 0; j < 70; j++) begin
            step();
            if (j == 63) check("rst_restart_63", 32'(POR_OUT_B), 32'h0);
            if (j == 64) check("rst_restart_64", 32'(POR_OUT_B), 32'h1);
        end

`ifdef RD53_POR_OVERRIDE_EN
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            POR_OVR_EN  = (i >= 10 && i < 90);
            POR_OVR_VAL = N_CH'(4'b1010);
            step();
            if (i == 10) check("ovr_load", 32'(POR_OUT_B), 32'ha);
            if (i == 88) check("ovr_done", 32'(POR_DONE), 32'h1);
            if (i == 90) check("ovr_exit", 32'(POR_OUT_B), 32'hf);
        end
        POR_OVR_EN = 1'b0;
`endif

        // Randomised pin activity with occasional resets.
        burst = 0;
        lvl   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0) begin
                lvl = !lvl;
                if (lvl) burst = int'($urandom_range(1, 150));
                else if ($urandom_range(0, 3) == 0) burst = int'($urandom_range(20, 60));
                else burst = int'($urandom_range(1, FILT_LEN + 2));
            end
            burst--;
            POR_EXT_CAP = lvl;
            RST = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
